// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display monitor: segment code table,
// segment-to-BCD decode and frame FSM state encoding.
package seg_pkg;

  // abcdefg, active low (0 = segment lit)
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0001100;

  typedef logic [1:0] frame_state_t;

  localparam frame_state_t ST_IDLE      = 2'd0;
  localparam frame_state_t ST_HAVE_ONES = 2'd1;
  localparam frame_state_t ST_HAVE_TENS = 2'd2;
  localparam frame_state_t ST_EMIT      = 2'd3;

  // Returns {legal, digit[3:0]}; illegal codes return all zeros.
  function automatic logic [4:0] seg_to_bcd(input logic [6:0] seg);
    case (seg)
      SEG_0:   return {1'b1, 4'd0};
      SEG_1:   return {1'b1, 4'd1};
      SEG_2:   return {1'b1, 4'd2};
      SEG_3:   return {1'b1, 4'd3};
      SEG_4:   return {1'b1, 4'd4};
      SEG_5:   return {1'b1, 4'd5};
      SEG_6:   return {1'b1, 4'd6};
      SEG_7:   return {1'b1, 4'd7};
      SEG_8:   return {1'b1, 4'd8};
      SEG_9:   return {1'b1, 4'd9};
      default: return 5'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Synchronises the segment/anode bus and emits one accept pulse per stable
// single-anode sample, together with the slot and segment code that was seen.
module seg_stable_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_n,
  input  logic [1:0] an_n,
  output logic       accept,
  output logic       slot,
  output logic [6:0] code
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0][6:0] seg_sync;
  logic [SYNC_STAGES-1:0][1:0] an_sync;
  logic [6:0] cur_seg, prev_seg;
  logic [1:0] cur_an, prev_an;
  logic [7:0] cnt, cnt_next;
  logic       valid, same, hit;

  assign cur_seg = seg_sync[SYNC_STAGES-1];
  assign cur_an  = an_sync[SYNC_STAGES-1];
  assign valid   = (cur_an == 2'b10) || (cur_an == 2'b01);
  assign same    = (cur_an == prev_an) && (cur_seg == prev_seg);

  always_comb begin
    cnt_next = cnt;
    if (!valid)
      cnt_next = 8'd0;
    else if (!same)
      cnt_next = 8'd1;
    else if (cnt != 8'hFF)
      cnt_next = cnt + 8'd1;
  end

  // A reload to 1 is a fresh period even when the count was already 1.
  assign hit = valid && (cnt_next == STABLE) && (!same || (cnt != STABLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sync <= '0;
      an_sync  <= '0;
      prev_seg <= '0;
      prev_an  <= '0;
      cnt      <= '0;
      accept   <= 1'b0;
      slot     <= 1'b0;
      code     <= '0;
    end else begin
      seg_sync <= {seg_sync[SYNC_STAGES-2:0], seg_n};
      an_sync  <= {an_sync[SYNC_STAGES-2:0], an_n};
      prev_seg <= cur_seg;
      prev_an  <= cur_an;
      cnt      <= cnt_next;
      accept   <= hit;
      slot     <= cur_an[0];
      code     <= cur_seg;
    end
  end

endmodule

// File: rtl/seg_display_monitor.sv
// Recovers the two BCD digits shown on a multiplexed active-low seven-segment
// bus and delivers them as a packed frame over a valid/ready handshake.
//
// state      | meaning
// IDLE       | no digit captured for the current frame
// HAVE_ONES  | ones digit captured, waiting for tens
// HAVE_TENS  | tens digit captured, waiting for ones
// EMIT       | both digits captured, loading the output frame
module seg_display_monitor
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_n,
  input  logic [1:0] an_n,
  output logic [7:0] frame_data,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic [1:0] pattern_err,
  output logic       overrun,
  input  logic       err_clr
);

  logic         accept, slot;
  logic [6:0]   code;
  logic [4:0]   dec;
  logic         legal, ones_cap, tens_cap;
  logic [1:0]   err_set;
  logic [3:0]   ones_d, tens_d;
  logic         have_ones, have_tens;
  frame_state_t state, state_next;

  seg_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .seg_n (seg_n),
    .an_n  (an_n),
    .accept(accept),
    .slot  (slot),
    .code  (code)
  );

  assign dec      = seg_to_bcd(code);
  assign legal    = dec[4];
  assign ones_cap = accept && legal && !slot;
  assign tens_cap = accept && legal && slot;
  assign err_set  = {accept && !legal && slot, accept && !legal && !slot};

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (ones_cap)      state_next = ST_HAVE_ONES;
        else if (tens_cap) state_next = ST_HAVE_TENS;
      end
      ST_HAVE_ONES: if (tens_cap && have_ones) state_next = ST_EMIT;
      ST_HAVE_TENS: if (ones_cap && have_tens) state_next = ST_EMIT;
      default: begin
        // A capture landing in the EMIT cycle starts the next frame.
        if (ones_cap)      state_next = ST_HAVE_ONES;
        else if (tens_cap) state_next = ST_HAVE_TENS;
        else               state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ones_d      <= '0;
      tens_d      <= '0;
      have_ones   <= 1'b0;
      have_tens   <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      pattern_err <= '0;
      overrun     <= 1'b0;
    end else begin
      state <= state_next;
      if (ones_cap) ones_d <= dec[3:0];
      if (tens_cap) tens_d <= dec[3:0];

      if (state == ST_EMIT) begin
        have_ones   <= ones_cap;
        have_tens   <= tens_cap;
        frame_data  <= {tens_d, ones_d};
        frame_valid <= 1'b1;
      end else begin
        have_ones <= have_ones | ones_cap;
        have_tens <= have_tens | tens_cap;
        if (frame_valid && frame_ready) frame_valid <= 1'b0;
      end

      pattern_err <= err_set | (pattern_err & ~{tens_cap, ones_cap} & ~{2{err_clr}});
      overrun     <= ((state == ST_EMIT) && frame_valid && !frame_ready) |
                     (overrun & ~err_clr);
    end
  end

endmodule

// File: tb/tb_seg_display_monitor.sv
// Directed and randomized checks of seg_display_monitor against a dwell-level
// reference model of the display bus.
module tb_seg_display_monitor;

  localparam int S  = 4;
  localparam int SY = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_n = 7'h7F;
  logic [1:0] an_n = 2'b11;
  logic       frame_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic [1:0] pattern_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  bit rand_phase = 1'b0;
  int rand_frames = 0;

  logic [6:0] codes [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0001100};

  logic [7:0] exp_q [$];
  logic [3:0] m_digit [2];
  bit         m_have [2];
  logic [1:0] m_perr;

  seg_display_monitor #(.STABLE_CYCLES(S), .SYNC_STAGES(SY)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .pattern_err(pattern_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [1:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    repeat (n) begin
      @(posedge clk); #1;
      if (frame_valid) valid_seen++;
    end
  endtask

  function automatic int lookup(input logic [6:0] seg);
    for (int i = 0; i < 10; i++) if (codes[i] == seg) return i;
    return -1;
  endfunction

  task automatic model_accept(input int s, input logic [6:0] seg);
    int d;
    d = lookup(seg);
    if (d < 0) begin
      m_perr[s] = 1'b1;
    end else begin
      m_digit[s] = 4'(d);
      m_have[s]  = 1'b1;
      m_perr[s]  = 1'b0;
      if (m_have[0] && m_have[1]) begin
        exp_q.push_back({m_digit[1], m_digit[0]});
        m_have[0] = 1'b0;
        m_have[1] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rand_phase && frame_valid && frame_ready) begin
      rand_frames++;
      if (exp_q.size() == 0) check("rand_extra_frame", {24'h0, frame_data}, 32'hFFFF_FFFF);
      else                   check("rand_frame", {24'h0, frame_data}, {24'h0, exp_q.pop_front()});
    end
  end

  initial begin
    int k;
    bit found;
    logic [1:0] r_an, p_an;
    logic [6:0] r_seg, p_seg;
    int run_len, old_len, len;

    // Reset and idle
    #12;
    check("rst_data", {24'h0, frame_data}, 0);
    check("rst_valid", {31'h0, frame_valid}, 0);
    check("rst_perr", {30'h0, pattern_err}, 0);
    check("rst_overrun", {31'h0, overrun}, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    hold(2'b11, 7'h7F, 50);
    check("idle_no_valid", valid_seen, 0);
    check("idle_perr", {30'h0, pattern_err}, 0);

    // Basic capture with latency measurement
    frame_ready = 1'b1;
    hold(2'b10, codes[5], 10);
    an_n = 2'b01; seg_n = codes[2];
    k = 0; found = 1'b0;
    while (!found && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (frame_valid) found = 1'b1;
    end
    check("basic_timeout", {31'h0, found}, 1);
    check("basic_latency", k - 1, SY + S + 1);
    check("basic_data", {24'h0, frame_data}, 32'h25);
    @(posedge clk); #1;
    check("basic_one_cycle", {31'h0, frame_valid}, 0);
    hold(2'b01, codes[2], 5);

    // Glitch rejection and ghosting
    valid_seen = 0;
    for (int i = 0; i < 20; i++) hold(2'b10, (i % 2) ? codes[1] : codes[7], 2);
    hold(2'b00, codes[8], 20);
    hold(2'b01, codes[3], 10);
    hold(2'b11, 7'h7F, 20);
    check("glitch_no_frame", valid_seen, 0);
    check("glitch_perr", {30'h0, pattern_err}, 0);
    hold(2'b10, codes[4], 10);
    check("glitch_frame_count", valid_seen, 1);
    check("glitch_frame_data", {24'h0, frame_data}, 32'h34);

    // Illegal pattern on tens slot
    valid_seen = 0;
    hold(2'b01, 7'h7F, 10);
    check("illegal_perr_set", {30'h0, pattern_err}, 2'b10);
    hold(2'b01, codes[9], 10);
    check("illegal_perr_clr", {30'h0, pattern_err}, 0);
    hold(2'b10, codes[6], 10);
    check("illegal_frame_count", valid_seen, 1);
    check("illegal_frame_data", {24'h0, frame_data}, 32'h96);

    // Backpressure and overrun
    frame_ready = 1'b0;
    hold(2'b10, codes[7], 10);
    hold(2'b01, codes[3], 10);
    check("bp_first_valid", {31'h0, frame_valid}, 1);
    check("bp_first_data", {24'h0, frame_data}, 32'h37);
    check("bp_first_overrun", {31'h0, overrun}, 0);
    hold(2'b10, codes[8], 10);
    hold(2'b01, codes[4], 10);
    check("bp_second_valid", {31'h0, frame_valid}, 1);
    check("bp_second_data", {24'h0, frame_data}, 32'h48);
    check("bp_overrun", {31'h0, overrun}, 1);
    frame_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drop_valid", {31'h0, frame_valid}, 0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("bp_err_clr", {31'h0, overrun}, 0);

    // Reset mid-frame discards the captured ones digit
    valid_seen = 0;
    hold(2'b10, codes[7], 10);
    rst_n = 1'b0;
    hold(2'b10, codes[7], 2);
    rst_n = 1'b1;
    hold(2'b01, codes[1], 10);
    hold(2'b11, 7'h7F, 20);
    check("midrst_no_frame", valid_seen, 0);
    hold(2'b10, codes[2], 10);
    check("midrst_frame_count", valid_seen, 1);
    check("midrst_frame_data", {24'h0, frame_data}, 32'h12);

    // Randomized dwells against the reference model
    rst_n = 1'b0;
    hold(2'b11, 7'h7F, 2);
    rst_n = 1'b1;
    hold(2'b11, 7'h7F, 5);
    m_have[0] = 1'b0; m_have[1] = 1'b0; m_perr = 2'b00;
    m_digit[0] = 4'd0; m_digit[1] = 4'd0;
    p_an = 2'b11; p_seg = 7'h7F; run_len = 0;
    rand_phase = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        r_an = p_an; r_seg = p_seg;
      end else begin
        k = $urandom_range(0, 9);
        r_an = (k == 0) ? 2'b11 : (k == 1) ? 2'b00 : (k < 6) ? 2'b10 : 2'b01;
        r_seg = ($urandom_range(0, 9) < 7) ? codes[$urandom_range(0, 9)] : 7'($urandom);
      end
      len = $urandom_range(1, 10);
      if (r_an != 2'b10 && r_an != 2'b01) begin
        old_len = 0; run_len = 0;
      end else begin
        old_len = (run_len > 0 && r_an == p_an && r_seg == p_seg) ? run_len : 0;
        run_len = old_len + len;
        if (old_len < S && run_len >= S) model_accept((r_an == 2'b01) ? 1 : 0, r_seg);
      end
      p_an = r_an; p_seg = r_seg;
      hold(r_an, r_seg, len);
    end
    hold(2'b11, 7'h7F, 30);
    rand_phase = 1'b0;
    check("rand_pending", exp_q.size(), 0);
    check("rand_some_frames", {31'h0, rand_frames > 0}, 1);
    check("rand_perr", {30'h0, pattern_err}, {30'h0, m_perr});
    check("rand_overrun", {31'h0, overrun}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
